// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: radix-2 shift-add
// multiply and restoring divide over WIDTH cycles, plus MFHI/MFLO/MTHI/MTLO.
//
// state | meaning
// IDLE  | ready; accepts mul/div, performs MTHI/MTLO, serves MFHI/MFLO
// MUL   | shift-add multiply in progress
// DIV   | restoring shift-subtract divide in progress
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_rem, r_q, r_b;
  logic             r_neg_q, r_neg_r, r_dbz;

  logic             w_op_valid, w_signed, w_is_mul, w_is_div;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_rem_next, w_q_next, w_quo_fix, w_rem_fix;

  assign w_op_valid = (op >= OP_MULT) && (op <= OP_MTLO);
  assign w_is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_signed   = (op == OP_MULT) || (op == OP_DIV);
  assign w_a_mag    = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag    = (w_signed && B[WIDTH-1]) ? -B : B;

  // Multiply: {r_rem, r_q} is the product register, multiplier bits drain from r_q[0].
  assign w_sum      = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_b : {WIDTH{1'b0}})};
  assign w_prod     = {w_sum, r_q[WIDTH-1:1]};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Divide: dividend bits shift out of r_q's top while quotient bits shift in.
  assign w_trial    = {r_rem, r_q[WIDTH-1]} - {1'b0, r_b};
  assign w_rem_next = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_q[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quo_fix  = r_dbz ? {WIDTH{1'b1}} : (r_neg_q ? -w_q_next : w_q_next);
  assign w_rem_fix  = r_neg_r ? -w_rem_next : w_rem_next;

  assign busy   = (r_state != S_IDLE);
  assign stall  = busy && w_op_valid;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = (!stall && op == OP_MFHI) ? r_hi :
                  (!stall && op == OP_MFLO) ? r_lo : {WIDTH{1'b0}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul || w_is_div) begin
            r_state <= w_is_mul ? S_MUL : S_DIV;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r <= w_signed && A[WIDTH-1];
            r_dbz   <= (B == '0);
          end else if (op == OP_MTHI) begin
            r_hi <= A;
          end else if (op == OP_MTLO) begin
            r_lo <= A;
          end
        end
        S_MUL: begin
          r_rem <= w_sum[WIDTH:1];
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_hi    <= w_rem_fix;
            r_lo    <= w_quo_fix;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
